cellrv32_cpu_cp_dispatch: RTL and testbench
===========================================

Name: cellrv32_cpu_cp_dispatch

Overview:
- CPU-side initiator for the co-processor interface.
- Issues a one-cycle start to exactly one selected co-processor (shifter, mul/div, bit-manip, ...) and waits for its valid.
- Collects the OR-combined result bus and hands a registered result plus a done strobe back to the control unit.
- Handles trap abort, illegal selection and, optionally, a hang timeout.

Parameters:
- XLEN, 32: data path width.
- NUM_CP, 8: number of attached co-processors, 1..16.
- TIMEOUT_LOG2, 7: the RUN state times out after 2**TIMEOUT_LOG2 cycles (only with the optional feature).

Ports:
- clk_i  in  1  global clock, rising edge.
- rstn_i  in  1  global reset, asynchronous, active-low.
- req_i  in  1  control unit requests a co-processor operation; sampled only in IDLE.
- sel_i  in  index_size_f(NUM_CP)  co-processor index for the request.
- trap_i  in  1  CPU trap; aborts any operation in progress.
- cp_start_o  out  NUM_CP  one-hot start strobes, one per co-processor.
- cp_valid_i  in  NUM_CP  per-co-processor "result available next cycle" flags.
- cp_res_i  in  NUM_CP*XLEN  flattened result buses; slice k = bits [k*XLEN +: XLEN]. Each co-processor drives zero when idle.
- res_o  out  XLEN  registered result.
- done_o  out  1  one-cycle pulse; res_o is valid in that cycle.
- busy_o  out  1  state != IDLE.
- err_o  out  1  one-cycle pulse on illegal select or timeout.

Behaviour:
- Reset (async): state=IDLE, res_o=0, done_o=0, err_o=0, sel_q=0, timeout counter=0; cp_start_o=0 combinationally.
- States:
  - IDLE: waiting for a request.
  - RUN: operation issued, waiting for valid.
  - RESULT: result bus is live this cycle.
- cp_start_o[k] = (state==IDLE) & req_i & (sel_i==k) & (sel_i<NUM_CP). Combinational and never more than one bit.
- IDLE:
  - req_i with sel_i>=NUM_CP: no start; err_o=1 next cycle; stay IDLE.
  - req_i with a legal select: sel_q<=sel_i.
  - If cp_valid_i[sel_i] is high in the same cycle (fast co-processors): go to RESULT, else go to RUN.
- RUN:
  - cp_valid_i[sel_q]: go to RESULT.
  - Valid from a non-selected index is ignored.
- RESULT:
  - res_o <= OR over k of cp_res_i slice k.
  - done_o<=1 for the next cycle only; go to IDLE.
- Trap priority: trap_i has priority over everything in RUN and RESULT.
  - Go to IDLE; no done_o; res_o holds its old value.
  - In IDLE, a trap in the same cycle as req_i suppresses the start.
- Back-to-back: a new req_i is accepted in the IDLE cycle in which done_o is high.
- Latency, request to done_o:
  - Valid together with start: 2 cycles.
  - Valid N cycles after start: N+2 cycles.
- done_o and err_o are never high in the same cycle.
- busy_o is combinational from state.
- res_o changes only on RESULT; it is not cleared by done_o falling.

Optional Feature:
- Macro: CELLRV32_CP_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_LOG2+1-bit counter clears on entry to RUN and increments each RUN cycle.
  - When its MSB sets without a valid: err_o=1 next cycle, go to IDLE, no done_o.
  - Valid in the same cycle as the MSB setting wins (go to RESULT).
- Undefined: no counter; RUN waits indefinitely (exit only by valid, trap or reset); err_o only for illegal select.

Decomposition:
- Package cellrv32_package gets:
  - cp_disp_state_t enum {CP_IDLE, CP_RUN, CP_RESULT};
  - localparam CP_SEL_W via index_size_f(NUM_CP);
  - CP index constants (CP_SEL_SHIFTER=0, CP_SEL_MULDIV=1, ...).
- One sub-module, cellrv32_cpu_cp_res_or: parameterised NUM_CP×XLEN OR-reduction of the flattened result bus (purely combinational).
- FSM, counter and output registers stay in the top module.

Test Plan:
- Fast co-processor: req_i, sel_i=0, model asserts cp_valid_i[0] in the same cycle and drives 0x0000_00F0 the next cycle -> cp_start_o=8'h01 for one cycle; done_o 2 cycles after req; res_o=0x0000_00F0.
- Serial co-processor: sel_i=2, valid 31 cycles after start, result 0x8000_0000 -> busy_o high for 32 cycles; done_o at cycle 33; res_o=0x8000_0000; cp_start_o pulsed exactly once.
- Trap abort: sel_i=1, trap_i at cycle 5 of RUN; then a later valid is asserted -> state IDLE, no done_o; res_o keeps its previous value; stray valid ignored.
- Illegal select with NUM_CP=8: req_i, sel_i=9 (sel_i is 4 bits wide at NUM_CP=8, so 9 is representable) -> cp_start_o=0; err_o pulse next cycle; busy_o stays 0.
- Timeout with CELLRV32_CP_TIMEOUT_EN, TIMEOUT_LOG2=3: no valid -> err_o pulse 9 cycles after start; IDLE. Without the macro: busy_o stays 1 indefinitely.
- Back-to-back plus async reset: second req_i in the done_o cycle is accepted. Then rstn_i asserted mid-RUN -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/cellrv32_cpu_cp_dispatch_pkg.sv
// Shared types and constants for the CPU co-processor dispatch logic.
// Index widths are sized so that one out-of-range select value is always representable.
package cellrv32_package;

    // Bits needed to hold the value n; NUM_CP itself must fit so illegal selects can be expressed.
    function automatic int unsigned index_size_f(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) <= 64'(n)) begin
            w++;
        end
        return w;
    endfunction

    localparam int unsigned CP_NUM_DEFAULT = 8;
    localparam int unsigned CP_SEL_W       = index_size_f(CP_NUM_DEFAULT);

    localparam int unsigned CP_SEL_SHIFTER  = 0;
    localparam int unsigned CP_SEL_MULDIV   = 1;
    localparam int unsigned CP_SEL_BITMANIP = 2;
    localparam int unsigned CP_SEL_FPU      = 3;
    localparam int unsigned CP_SEL_CFU      = 4;
    localparam int unsigned CP_SEL_CONDOPS  = 5;

    typedef enum logic [1:0] {
        CP_IDLE,
        CP_RUN,
        CP_RESULT
    } cp_disp_state_t;

endpackage

// File: rtl/cellrv32_cpu_cp_dispatch_res_or.sv
// OR-reduction of the flattened co-processor result buses into one XLEN word.
// Idle co-processors drive zero, so the OR yields the active unit's result.
module cellrv32_cpu_cp_res_or
    import cellrv32_package::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NUM_CP = CP_NUM_DEFAULT
) (
    input  logic [NUM_CP*XLEN-1:0] res_bus,
    output logic [XLEN-1:0]        res
);

    always_comb begin
        res = '0;
        for (int unsigned k = 0; k < NUM_CP; k++) begin
            res = res | res_bus[k*XLEN +: XLEN];
        end
    end

endmodule

// File: rtl/cellrv32_cpu_cp_dispatch.sv
// CPU-side co-processor dispatcher: one-hot start, wait for valid, capture the OR'd result.
// Optional hang timeout in RUN is enabled by defining CELLRV32_CP_TIMEOUT_EN.
module cellrv32_cpu_cp_dispatch
    import cellrv32_package::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NUM_CP       = 8,
    parameter int unsigned TIMEOUT_LOG2 = 7
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic                             req_i,
    input  logic [index_size_f(NUM_CP)-1:0]  sel_i,
    input  logic                             trap_i,
    output logic [NUM_CP-1:0]                cp_start_o,
    input  logic [NUM_CP-1:0]                cp_valid_i,
    input  logic [NUM_CP*XLEN-1:0]           cp_res_i,
    output logic [XLEN-1:0]                  res_o,
    output logic                             done_o,
    output logic                             busy_o,
    output logic                             err_o
);

    localparam int unsigned SEL_W = index_size_f(NUM_CP);

    if (NUM_CP < 1 || NUM_CP > 16 || TIMEOUT_LOG2 < 1 || TIMEOUT_LOG2 > 30) begin : g_bad_cfg
        $error("cellrv32_cpu_cp_dispatch: NUM_CP must be 1..16, TIMEOUT_LOG2 1..30");
    end

    cp_disp_state_t    state_q;
    logic [SEL_W-1:0]  sel_q;
    logic [XLEN-1:0]   res_q;
    logic              done_q;
    logic              err_q;

    logic              sel_legal;
    logic [NUM_CP-1:0] start_dec;
    logic [NUM_CP-1:0] start_vec;
    logic              valid_fast;
    logic              valid_run;
    logic [XLEN-1:0]   res_or;

    cellrv32_cpu_cp_res_or #(
        .XLEN   (XLEN),
        .NUM_CP (NUM_CP)
    ) u_res_or (
        .res_bus (cp_res_i),
        .res     (res_or)
    );

    // Start only from IDLE with a legal select; a trap or reset suppresses it.
    assign sel_legal  = (sel_i < SEL_W'(NUM_CP));
    assign start_dec  = NUM_CP'(1) << sel_i;
    assign start_vec  = (rstn_i && (state_q == CP_IDLE) && req_i && !trap_i && sel_legal)
                        ? start_dec : '0;
    assign valid_fast = |(cp_valid_i & start_vec);

    always_comb begin
        valid_run = 1'b0;
        for (int unsigned k = 0; k < NUM_CP; k++) begin
            if (sel_q == SEL_W'(k)) begin
                valid_run = cp_valid_i[k];
            end
        end
    end

`ifdef CELLRV32_CP_TIMEOUT_EN
    localparam int unsigned CNT_W = TIMEOUT_LOG2 + 1;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    assign cnt_inc = cnt_q + CNT_W'(1);
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= CP_IDLE;
            sel_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef CELLRV32_CP_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                CP_IDLE: begin
                    if (req_i && !trap_i) begin
                        if (!sel_legal) begin
                            err_q <= 1'b1;
                        end else begin
                            sel_q   <= sel_i;
                            state_q <= valid_fast ? CP_RESULT : CP_RUN;
`ifdef CELLRV32_CP_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end
                    end
                end
                CP_RUN: begin
`ifdef CELLRV32_CP_TIMEOUT_EN
                    cnt_q <= cnt_inc;
`endif
                    if (trap_i) begin
                        state_q <= CP_IDLE;
                    end else if (valid_run) begin
                        state_q <= CP_RESULT;
`ifdef CELLRV32_CP_TIMEOUT_EN
                    end else if (cnt_inc[CNT_W-1]) begin
                        state_q <= CP_IDLE;
                        err_q   <= 1'b1;
`endif
                    end
                end
                CP_RESULT: begin
                    state_q <= CP_IDLE;
                    if (!trap_i) begin
                        res_q  <= res_or;
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= CP_IDLE;
            endcase
        end
    end

    assign cp_start_o = start_vec;
    assign res_o      = res_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign busy_o     = (state_q != CP_IDLE);

endmodule

// File: tb/tb_cellrv32_cpu_cp_dispatch.sv
// Bench for cellrv32_cpu_cp_dispatch: per-cycle timeline model built from the latency rules.
// Works with and without CELLRV32_CP_TIMEOUT_EN.
module tb_cellrv32_cpu_cp_dispatch;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NCP  = 8;
    localparam int unsigned TL   = 6;
    localparam int          TMO  = 1 << TL;
    localparam int          MAXC = 1024;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req;
    logic [3:0]    sel;
    logic          trap;
    logic [7:0]    cp_start;
    logic [7:0]    valid;
    logic [255:0]  res_bus;
    logic [31:0]   res;
    logic          done;
    logic          busy;
    logic          err;

    cellrv32_cpu_cp_dispatch #(
        .XLEN         (XLEN),
        .NUM_CP       (NCP),
        .TIMEOUT_LOG2 (TL)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .req_i      (req),
        .sel_i      (sel),
        .trap_i     (trap),
        .cp_start_o (cp_start),
        .cp_valid_i (valid),
        .cp_res_i   (res_bus),
        .res_o      (res),
        .done_o     (done),
        .busy_o     (busy),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected per-cycle output timeline
    logic [7:0]  e_start [MAXC];
    logic        e_busy  [MAXC];
    logic        e_done  [MAXC];
    logic        e_err   [MAXC];
    logic [31:0] e_res   [MAXC];

    int  checks   = 0;
    int  failures = 0;
    bit  chk_en   = 1'b0;
    int  n_start  = 0;
    int  n_done   = 0;
    int  n_err    = 0;
    int  n_busy   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic set_res(input int c, input logic [31:0] v);
        for (int j = c; j < MAXC; j++) e_res[j] = v;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            check("start", 32'(cp_start), 32'(e_start[cyc]));
            check("busy",  32'(busy),     32'(e_busy[cyc]));
            check("done",  32'(done),     32'(e_done[cyc]));
            check("err",   32'(err),      32'(e_err[cyc]));
            check("res",   res,           e_res[cyc]);
            if (cp_start != 8'h00) n_start++;
            if (busy) n_busy++;
            if (done) n_done++;
            if (err)  n_err++;
        end
    end

    // One request: s=select, n=valid delay after start (-1 never), trap_off=trap cycle (-1 none).
    task automatic do_op(input int s, input int n, input logic [31:0] r, input int trap_off);
        int  t;
        int  endo;
        int  last_busy;
        bit  legal;
        bit  timeout;
        t       = cyc;
        legal   = (s < NCP);
        timeout = 1'b0;
        if (trap_off == 0) begin
            endo = 1;
        end else if (!legal) begin
            e_err[t+1] = 1'b1;
            endo = 1;
        end else begin
            e_start[t] = 8'(1 << s);
`ifdef CELLRV32_CP_TIMEOUT_EN
            timeout = (n < 0) || (n > TMO);
`endif
            if (timeout)     last_busy = t + TMO;
            else if (n < 0)  last_busy = MAXC + 100;
            else             last_busy = t + n + 1;
            if (trap_off > 0 && t + trap_off <= last_busy) begin
                last_busy = t + trap_off;
                endo = trap_off + 1;
            end else if (timeout) begin
                e_err[last_busy+1] = 1'b1;
                endo = TMO + 1;
            end else begin
                e_done[t+n+2] = 1'b1;
                set_res(t + n + 2, r);
                endo = n + 2;
            end
            for (int c = t + 1; c <= last_busy && c < MAXC; c++) e_busy[c] = 1'b1;
        end
        for (int i = 0; i < endo; i++) begin
            req     = (i == 0);
            sel     = 4'(s);
            trap    = (i == trap_off);
            valid   = '0;
            res_bus = '0;
            if (legal && i == n) valid[3'(s)] = 1'b1;
            if (i == 1) valid[3'((s + 3) % 8)] = 1'b1;
            if (legal && i == n + 1) res_bus[s*32 +: 32] = r;
            nxt();
        end
        req = 1'b0; trap = 1'b0; valid = '0; res_bus = '0; sel = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    int b_start, b_done, b_busy, b_err, t0;
    int tab_sel [4] = '{0, 2, 7, 3};
    int tab_n   [4] = '{1, 4, 0, 7};
    logic [31:0] tab_r [4] = '{32'h0000_0001, 32'hCAFE_BABE, 32'hFFFF_FFFF, 32'h0F0F_0F0F};

    initial begin
        for (int c = 0; c < MAXC; c++) begin
            e_start[c] = '0; e_busy[c] = 1'b0; e_done[c] = 1'b0; e_err[c] = 1'b0; e_res[c] = '0;
        end
        rstn = 1'b0; req = 1'b1; sel = '0; trap = 1'b0; valid = '0; res_bus = '0;
        #2;
        check("rst_start", 32'(cp_start), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_done",  32'(done), 32'h0);
        check("rst_err",   32'(err),  32'h0);
        check("rst_res",   res, 32'h0);
        req = 1'b0;
        repeat (3) nxt();
        rstn   = 1'b1;
        chk_en = 1'b1;
        nxt();

        // fast co-processor: valid with start
        b_start = n_start; b_done = n_done;
        do_op(0, 0, 32'h0000_00F0, -1);
        check("fast_done", 32'(done), 32'h1);
        check("fast_res",  res, 32'h0000_00F0);
        check("fast_nstart", 32'(n_start - b_start), 32'd1);
        nxt();

        // serial co-processor: valid 31 cycles after start
        b_start = n_start; b_busy = n_busy;
        do_op(2, 31, 32'h8000_0000, -1);
        check("ser_done", 32'(done), 32'h1);
        check("ser_res",  res, 32'h8000_0000);
        check("ser_nbusy",  32'(n_busy - b_busy), 32'd32);
        check("ser_nstart", 32'(n_start - b_start), 32'd1);
        nxt();

        // trap in RUN, then stray valid/result
        b_done = n_done;
        do_op(1, 20, 32'hDEAD_0000, 5);
        valid[1] = 1'b1; nxt();
        valid = '0; res_bus[63:32] = 32'hDEAD_BEEF; nxt();
        res_bus = '0; nxt();
        check("trap_res",  res, 32'h8000_0000);
        check("trap_busy", 32'(busy), 32'h0);
        // trap during RESULT, then trap together with request
        do_op(3, 2, 32'h1111_1111, 3);
        b_start = n_start;
        do_op(4, 5, 32'h2222_2222, 0);
        nxt();
        check("trapres_res", res, 32'h8000_0000);
        check("trap_ndone",  32'(n_done - b_done), 32'd0);
        check("trapreq_nstart", 32'(n_start - b_start), 32'd0);

        // illegal selects 9 and 8, then highest legal select
        b_start = n_start; b_busy = n_busy;
        do_op(9, 0, 32'h0, -1);
        check("ill9_err", 32'(err), 32'h1);
        do_op(8, 0, 32'h0, -1);
        check("ill8_err", 32'(err), 32'h1);
        check("ill_nstart", 32'(n_start - b_start), 32'd0);
        check("ill_nbusy",  32'(n_busy - b_busy), 32'd0);
        do_op(7, 1, 32'h0000_0007, -1);
        check("sel7_res", res, 32'h0000_0007);
        nxt();

        // hang: timeout error or indefinite busy ended by trap
        b_busy = n_busy; b_err = n_err;
`ifdef CELLRV32_CP_TIMEOUT_EN
        do_op(4, -1, 32'h0, -1);
        check("tmo_err",   32'(err), 32'h1);
        check("tmo_nbusy", 32'(n_busy - b_busy), 32'(TMO));
`else
        do_op(4, -1, 32'h0, 100);
        check("hang_nbusy", 32'(n_busy - b_busy), 32'd100);
        check("hang_nerr",  32'(n_err - b_err), 32'd0);
`endif
        // valid exactly at the timeout boundary still completes
        do_op(5, TMO, 32'h0000_0040, -1);
        check("bound_res", res, 32'h0000_0040);

        // back-to-back requests issued in the done cycle
        do_op(5, 3, 32'hA5A5_0001, -1);
        check("b2b1_done", 32'(done), 32'h1);
        do_op(6, 1, 32'h0000_1234, -1);
        check("b2b2_res", res, 32'h0000_1234);
        for (int k = 0; k < 4; k++) do_op(tab_sel[k], tab_n[k], tab_r[k], -1);
        check("tab_res", res, 32'h0F0F_0F0F);
        nxt();

        // async reset in the middle of RUN
        t0 = cyc;
        e_start[t0] = 8'h80;
        for (int c = t0 + 1; c <= t0 + 3; c++) e_busy[c] = 1'b1;
        req = 1'b1; sel = 4'd7;
        nxt();
        req = 1'b0; sel = '0;
        nxt();
        nxt();
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        #2;
        rstn = 1'b0; req = 1'b1; sel = '0;
        #1;
        check("arst_busy",  32'(busy), 32'h0);
        check("arst_res",   res, 32'h0);
        check("arst_start", 32'(cp_start), 32'h0);
        check("arst_done",  32'(done), 32'h0);
        check("arst_err",   32'(err), 32'h0);
        req = 1'b0;
        nxt();
        nxt();
        rstn = 1'b1;
        set_res(cyc, 32'h0);
        chk_en = 1'b1;
        nxt();
        do_op(3, 2, 32'h0000_0033, -1);
        check("post_rst_res", res, 32'h0000_0033);
        repeat (3) nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
